// File: rtl/fifo_pkg.sv
// fifo_pkg: sizing helpers and shared types for the fifo_thresh FIFO family.
package fifo_pkg;

    // Width needed to hold an occupancy value in the range 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a pointer spanning 0..depth-1; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        int w;
        w = $clog2(depth);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

    // Sticky error pair reported when FIFO_ERR_FLAGS_EN is defined.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_flags_t;

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: modulo-DEPTH pointer register with enable. DEPTH need not be
// a power of two, so the wrap back to zero is an explicit compare.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int PW    = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_r;

    // Advance on enable, wrapping from DEPTH-1 back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {PW{1'b0}};
        end else if (en) begin
            if (ptr_r == PW'(DEPTH - 1)) begin
                ptr_r <= {PW{1'b0}};
            end else begin
                ptr_r <= ptr_r + PW'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/fifo_thresh_chk.sv
// fifo_thresh_chk: formal properties for fifo_thresh, bound in only when
// FORMAL is defined. With FIFO_ERR_FLAGS_EN it also constrains the
// environment to legal traffic so the sticky error flags stay clear.
`ifdef FORMAL
module fifo_thresh_chk
    import fifo_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int CNTWID = cnt_width(DEPTH),
    parameter int PW     = ptr_width(DEPTH)
) (
    input logic              clk,
    input logic              rst,
    input logic              push,
    input logic              pop,
    input logic              push_ok,
    input logic              pop_ok,
    input logic              full,
    input logic              empty,
    input logic [CNTWID-1:0] count,
    input logic [PW-1:0]     wr_ptr,
    input logic [PW-1:0]     rd_ptr
);

    logic [CNTWID-1:0] ptr_diff_s;

    // Pointer distance modulo DEPTH, used to cross-check the count.
    always_comb begin
        ptr_diff_s = {CNTWID{1'b0}};
        if (wr_ptr >= rd_ptr) begin
            ptr_diff_s = CNTWID'(wr_ptr - rd_ptr);
        end else begin
            ptr_diff_s = CNTWID'(DEPTH) - CNTWID'(rd_ptr) + CNTWID'(wr_ptr);
        end
    end

    a_count_ptr: assert property (@(posedge clk) disable iff (!rst)
        (count == CNTWID'(DEPTH)) ? (wr_ptr == rd_ptr) : (count == ptr_diff_s));

    a_full_empty: assert property (@(posedge clk) disable iff (!rst)
        !(full && empty));

`ifdef FIFO_ERR_FLAGS_EN
    m_legal_push: assume property (@(posedge clk) disable iff (!rst)
        !(push && !push_ok));
    m_legal_pop: assume property (@(posedge clk) disable iff (!rst)
        !(pop && !pop_ok));
`endif

endmodule
`endif

// File: rtl/fifo_thresh.sv
// fifo_thresh: synchronous show-ahead FIFO for any DEPTH >= 2 with an
// explicit occupancy count and runtime almost-full / almost-empty
// thresholds. Illegal pushes (full) and pops (empty) are dropped.
// Optional macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module fifo_thresh
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int CNTWID = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [CNTWID-1:0] af_thresh,
    input  logic [CNTWID-1:0] ae_thresh,
    output logic [WIDTH-1:0]  data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNTWID-1:0] count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam int PW = ptr_width(DEPTH);

    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [CNTWID-1:0] count_r;
    logic [PW-1:0]     wr_ptr_s;
    logic [PW-1:0]     rd_ptr_s;
    logic              full_s;
    logic              empty_s;
    logic              pop_ok_s;
    logic              push_ok_s;

    // Status comes from the registered count only, never from pointers.
    assign full_s    = (count_r == CNTWID'(DEPTH));
    assign empty_s   = (count_r == {CNTWID{1'b0}});
    assign pop_ok_s  = pop & ~empty_s;
    // A push into a full FIFO is legal when a pop frees a slot this cycle.
    assign push_ok_s = push & (~full_s | pop_ok_s);

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst),
        .en    (push_ok_s),
        .ptr   (wr_ptr_s)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst),
        .en    (pop_ok_s),
        .ptr   (rd_ptr_s)
    );

    // Entry storage: cleared on reset, written at wr_ptr on an accepted push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_s] <= data_in;
        end
    end

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {CNTWID{1'b0}};
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNTWID'(1);
                2'b01:   count_r <= count_r - CNTWID'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign data_out     = mem_r[rd_ptr_s];
    assign full         = full_s;
    assign empty        = empty_s;
    assign count        = count_r;
    assign almost_full  = (count_r >= af_thresh);
    assign almost_empty = (count_r <= ae_thresh);

`ifdef FIFO_ERR_FLAGS_EN
    err_flags_t err_r;

    // Sticky error capture; only reset clears the flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 2'b00;
        end else begin
            if (push && !push_ok_s) begin
                err_r.overflow <= 1'b1;
            end
            if (pop && !pop_ok_s) begin
                err_r.underflow <= 1'b1;
            end
        end
    end

    assign overflow  = err_r.overflow;
    assign underflow = err_r.underflow;
`endif

`ifdef FORMAL
    fifo_thresh_chk #(.DEPTH(DEPTH), .CNTWID(CNTWID), .PW(PW)) u_chk (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .push_ok (push_ok_s),
        .pop_ok  (pop_ok_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (count_r),
        .wr_ptr  (wr_ptr_s),
        .rd_ptr  (rd_ptr_s)
    );
`endif

endmodule

// File: tb/tb_fifo_thresh.sv
// tb_fifo_thresh: self-checking bench for fifo_thresh at DEPTH 5, 8 and 2.
// A queue scoreboard models FIFO contents; stimulus tables add fixed
// expectations for the fill/drain and threshold sequences.
`timescale 1ns/1ps
module tb_fifo_thresh;

    typedef struct {
        logic       pu;
        logic       po;
        logic [7:0] din;
        int         e_count;
        logic       e_full;
        logic       e_empty;
        logic [7:0] e_dout;
        logic       e_af;
        logic       e_ae;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       push5 = 1'b0, pop5 = 1'b0;
    logic [7:0] din5 = 8'h00, dout5;
    logic [2:0] af5 = 3'd4, ae5 = 3'd1, cnt5;
    logic       full5, empty5, afl5, ael5;

    logic       push8 = 1'b0, pop8 = 1'b0;
    logic [7:0] din8 = 8'h00, dout8;
    logic [3:0] af8 = 4'd6, ae8 = 4'd2, cnt8;
    logic       full8, empty8, afl8, ael8;

    logic       push2 = 1'b0, pop2 = 1'b0;
    logic [7:0] din2 = 8'h00, dout2;
    logic [1:0] af2 = 2'd2, ae2 = 2'd0, cnt2;
    logic       full2, empty2, afl2, ael2;

`ifdef FIFO_ERR_FLAGS_EN
    logic ov5, uf5, ov8, uf8, ov2, uf2;
`endif

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int cur      = 5;
    logic [7:0] sb[$];
    vec_t t1[11];
    vec_t t4[7];
    int c, f, e, af, ae, dv;

    always #5 clk = ~clk;

    fifo_thresh #(.WIDTH(8), .DEPTH(5)) dut5 (
        .clk(clk), .rst(rst), .push(push5), .pop(pop5), .data_in(din5),
        .af_thresh(af5), .ae_thresh(ae5), .data_out(dout5), .full(full5),
        .empty(empty5), .almost_full(afl5), .almost_empty(ael5), .count(cnt5)
`ifdef FIFO_ERR_FLAGS_EN
        , .overflow(ov5), .underflow(uf5)
`endif
    );

    fifo_thresh #(.WIDTH(8), .DEPTH(8)) dut8 (
        .clk(clk), .rst(rst), .push(push8), .pop(pop8), .data_in(din8),
        .af_thresh(af8), .ae_thresh(ae8), .data_out(dout8), .full(full8),
        .empty(empty8), .almost_full(afl8), .almost_empty(ael8), .count(cnt8)
`ifdef FIFO_ERR_FLAGS_EN
        , .overflow(ov8), .underflow(uf8)
`endif
    );

    fifo_thresh #(.WIDTH(8), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .push(push2), .pop(pop2), .data_in(din2),
        .af_thresh(af2), .ae_thresh(ae2), .data_out(dout2), .full(full2),
        .empty(empty2), .almost_full(afl2), .almost_empty(ael2), .count(cnt2)
`ifdef FIFO_ERR_FLAGS_EN
        , .overflow(ov2), .underflow(uf2)
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        tot_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s (depth %0d): got 0x%0h, expected 0x%0h", nm, cur, act, exp);
        end
    endtask

    task automatic sample(output int oc, output int of, output int oe,
                          output int oaf, output int oae, output int od);
        case (cur)
            8: begin
                oc = int'(cnt8); of = int'(full8); oe = int'(empty8);
                oaf = int'(afl8); oae = int'(ael8); od = int'(dout8);
            end
            2: begin
                oc = int'(cnt2); of = int'(full2); oe = int'(empty2);
                oaf = int'(afl2); oae = int'(ael2); od = int'(dout2);
            end
            default: begin
                oc = int'(cnt5); of = int'(full5); oe = int'(empty5);
                oaf = int'(afl5); oae = int'(ael5); od = int'(dout5);
            end
        endcase
    endtask

    task automatic thresholds(output int at, output int et);
        case (cur)
            8:       begin at = int'(af8); et = int'(ae8); end
            2:       begin at = int'(af2); et = int'(ae2); end
            default: begin at = int'(af5); et = int'(ae5); end
        endcase
    endtask

    task automatic drive(input logic pu, input logic po, input logic [7:0] d);
        push5 = 1'b0; pop5 = 1'b0; push8 = 1'b0; pop8 = 1'b0; push2 = 1'b0; pop2 = 1'b0;
        case (cur)
            8:       begin push8 = pu; pop8 = po; din8 = d; end
            2:       begin push2 = pu; pop2 = po; din2 = d; end
            default: begin push5 = pu; pop5 = po; din5 = d; end
        endcase
    endtask

    // One clocked operation on the current instance, checked against the scoreboard.
    task automatic op(input logic pu, input logic po, input logic [7:0] d);
        int n, lc, lf, le, laf, lae, ld, at, et;
        bit pop_ok, push_ok;
        n = sb.size();
        pop_ok  = po && (n > 0);
        push_ok = pu && ((n < cur) || pop_ok);
        if (pop_ok) begin
            sample(lc, lf, le, laf, lae, ld);
            chk("pop_head", ld, int'(sb.pop_front()));
        end
        if (push_ok) sb.push_back(d);
        drive(pu, po, d);
        @(posedge clk); #1;
        sample(lc, lf, le, laf, lae, ld);
        thresholds(at, et);
        n = sb.size();
        chk("count", lc, n);
        chk("full", lf, int'(n == cur));
        chk("empty", le, int'(n == 0));
        chk("almost_full", laf, int'(n >= at));
        chk("almost_empty", lae, int'(n <= et));
        if (n > 0) chk("data_out", ld, int'(sb[0]));
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00);
        @(posedge clk); #1;
    endtask

    task automatic chk_vec(input string nm, input vec_t v);
        sample(c, f, e, af, ae, dv);
        chk({nm, "_count"}, c, v.e_count);
        chk({nm, "_full"}, f, int'(v.e_full));
        chk({nm, "_empty"}, e, int'(v.e_empty));
        chk({nm, "_af"}, af, int'(v.e_af));
        chk({nm, "_ae"}, ae, int'(v.e_ae));
        if (!v.e_empty) chk({nm, "_dout"}, dv, int'(v.e_dout));
    endtask

    initial begin
        // DEPTH=5, af=4, ae=1: fill, overfill, drain
        t1[0]  = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1};
        t1[1]  = '{1'b1, 1'b0, 8'h12, 2, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0};
        t1[2]  = '{1'b1, 1'b0, 8'h13, 3, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0};
        t1[3]  = '{1'b1, 1'b0, 8'h14, 4, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0};
        t1[4]  = '{1'b1, 1'b0, 8'h15, 5, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0};
        t1[5]  = '{1'b1, 1'b0, 8'h99, 5, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0};
        t1[6]  = '{1'b0, 1'b1, 8'h00, 4, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0};
        t1[7]  = '{1'b0, 1'b1, 8'h00, 3, 1'b0, 1'b0, 8'h13, 1'b0, 1'b0};
        t1[8]  = '{1'b0, 1'b1, 8'h00, 2, 1'b0, 1'b0, 8'h14, 1'b0, 1'b0};
        t1[9]  = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 8'h15, 1'b0, 1'b1};
        t1[10] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
        // DEPTH=8, af=6, ae=2: push seven words
        t4[0] = '{1'b1, 1'b0, 8'h40, 1, 1'b0, 1'b0, 8'h40, 1'b0, 1'b1};
        t4[1] = '{1'b1, 1'b0, 8'h41, 2, 1'b0, 1'b0, 8'h40, 1'b0, 1'b1};
        t4[2] = '{1'b1, 1'b0, 8'h42, 3, 1'b0, 1'b0, 8'h40, 1'b0, 1'b0};
        t4[3] = '{1'b1, 1'b0, 8'h43, 4, 1'b0, 1'b0, 8'h40, 1'b0, 1'b0};
        t4[4] = '{1'b1, 1'b0, 8'h44, 5, 1'b0, 1'b0, 8'h40, 1'b0, 1'b0};
        t4[5] = '{1'b1, 1'b0, 8'h45, 6, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0};
        t4[6] = '{1'b1, 1'b0, 8'h46, 7, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0};

        // Reset state on all three instances
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count5", int'(cnt5), 0);  chk("rst_empty5", int'(empty5), 1);
        chk("rst_full5", int'(full5), 0);  chk("rst_dout5", int'(dout5), 0);
        chk("rst_count8", int'(cnt8), 0);  chk("rst_empty8", int'(empty8), 1);
        chk("rst_ae8", int'(ael8), 1);     chk("rst_af8", int'(afl8), 0);
        chk("rst_count2", int'(cnt2), 0);  chk("rst_empty2", int'(empty2), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Test 1: fill/overfill/drain, table driven
        cur = 5;
        for (int i = 0; i < 11; i++) begin
            op(t1[i].pu, t1[i].po, t1[i].din);
            chk_vec("t1", t1[i]);
        end

        // Test 2: full-throughput push+pop while full, pointers wrap
        for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 8'hB0 + 8'(i));
        for (int i = 0; i < 7; i++) begin
            op(1'b1, 1'b1, 8'hA0 + 8'(i));
            chk("t2_count", int'(cnt5), 5);
        end
        for (int i = 0; i < 5; i++) op(1'b0, 1'b1, 8'h00);

        // Test 3: push+pop on empty
        op(1'b1, 1'b1, 8'h3C);
        chk("t3_dout", int'(dout5), 8'h3C);
`ifdef FIFO_ERR_FLAGS_EN
        chk("t3_underflow", int'(uf5), 1);
        chk("t3_overflow", int'(ov5), 1);
`endif
        idle();
`ifdef FIFO_ERR_FLAGS_EN
        chk("t3_underflow_sticky", int'(uf5), 1);
`endif
        op(1'b0, 1'b1, 8'h00);
        op(1'b0, 1'b1, 8'h00);

        // Test 4: thresholds on DEPTH=8
        cur = 8;
        for (int i = 0; i < 7; i++) begin
            op(t4[i].pu, t4[i].po, t4[i].din);
            chk_vec("t4", t4[i]);
        end
        af8 = 4'd8; #1;
        chk("t4_af_raise", int'(afl8), 0);
        af8 = 4'd0; #1;
        chk("t4_af_zero", int'(afl8), 1);
        ae8 = 4'd8; #1;
        chk("t4_ae_depth", int'(ael8), 1);
        ae8 = 4'd15; #1;
        chk("t4_ae_max", int'(ael8), 1);
        af8 = 4'd6; ae8 = 4'd2;
        for (int i = 0; i < 7; i++) op(1'b0, 1'b1, 8'h00);

        // Test 6: DEPTH=2 alternate push/pop, then full corner cases
        cur = 2;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) op(1'b1, 1'b0, 8'h60 + 8'(i));
            else            op(1'b0, 1'b1, 8'h00);
            chk("t6_never_full", int'(full2), 0);
        end
        op(1'b1, 1'b0, 8'h70);
        op(1'b1, 1'b0, 8'h71);
        op(1'b1, 1'b1, 8'h72);
        op(1'b1, 1'b0, 8'h73);
        op(1'b0, 1'b1, 8'h00);
        op(1'b0, 1'b1, 8'h00);

        // Test 5: asynchronous reset mid-cycle on DEPTH=5
        cur = 5;
        for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 8'h21 + 8'(i));
        drive(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_count", int'(cnt5), 0);
        chk("t5_empty", int'(empty5), 1);
        chk("t5_full", int'(full5), 0);
        chk("t5_dout", int'(dout5), 0);
        chk("t5_ae", int'(ael5), 1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("t5_overflow_clr", int'(ov5), 0);
        chk("t5_underflow_clr", int'(uf5), 0);
`endif
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        op(1'b1, 1'b0, 8'h55);
        chk("t5_dout_after", int'(dout5), 8'h55);
        idle();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/fifo_thresh.md
Name: fifo_thresh

Overview:
Parametrised synchronous FIFO, successor to the fixed power-of-two FIFO.
- Supports any DEPTH >= 2, not only powers of two.
- Keeps an explicit occupancy count.
- Provides runtime-programmable almost-full and almost-empty flags.
- Protects itself against illegal push/pop: illegal requests are dropped, never corrupt state.
- Used as the general buffering primitive between pipeline stages in the formal and simulation testbenches.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 8, number of entries; any integer >= 2
CNTWID, $clog2(DEPTH+1), width of occupancy count and threshold ports (derived; do not override)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; asynchronous assert, active-low (0 = reset); deassertion synchronous to clk by the integrator
push  input  1  write request; data_in written when the push is accepted
pop  input  1  read request; head entry removed when the pop is accepted
data_in  input  WIDTH  write data
af_thresh  input  CNTWID  almost-full threshold
ae_thresh  input  CNTWID  almost-empty threshold
data_out  output  WIDTH  head entry (show-ahead)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= af_thresh
almost_empty  output  1  count <= ae_thresh
count  output  CNTWID  current occupancy, 0..DEPTH

Behaviour:
Reset (rst = 0), taking effect immediately:
- wr_ptr, rd_ptr and count = 0; all entries = 0.
- Outputs: empty = 1, full = 0, data_out = 0, count = 0.
- almost_full / almost_empty follow the threshold compare.
- A reset mid-operation discards all contents with no residual state.

Acceptance, per cycle:
- pop_ok = pop & !empty
- push_ok = push & (!full | pop_ok)

Pointers:
- Range 0..DEPTH-1, wrapping explicitly from DEPTH-1 to 0 (no power-of-two wrap).
- wr_ptr advances on push_ok; rd_ptr advances on pop_ok.
- entries[wr_ptr] <= data_in on push_ok.

Count update:
- +1 on push_ok & !pop_ok.
- -1 on pop_ok & !push_ok.
- Unchanged otherwise.
- full and empty derive from the registered count only, never from a pointer compare.

Show-ahead read:
- data_out = entries[rd_ptr], combinational from registered state.
- Zero-cycle read latency: the head is visible the cycle after it is written.
- When empty, data_out is the stale entry at rd_ptr; no defined meaning.

Boundary cases:
- Push while full, no pop: dropped; state unchanged.
- Push + pop while full: both accepted; count stays DEPTH; the new word lands in the slot just vacated.
- Pop while empty: ignored.
- Push + pop while empty: push accepted, pop ignored; count becomes 1.

Thresholds:
- Compared against the registered count, unsigned, full CNTWID width.
- May change on any cycle; flags follow combinationally.
- af_thresh = 0 forces almost_full = 1.
- ae_thresh >= DEPTH forces almost_empty = 1.

Formal:
- Under FORMAL, assert count == (wr_ptr - rd_ptr) mod DEPTH, with the full case distinguished by count.
- Assert !(full & empty).

Optional Feature:
Macro FIFO_ERR_FLAGS_EN.
- Defined: adds two outputs.
  - overflow (1 bit): sticky; set on push & !push_ok.
  - underflow (1 bit): sticky; set on pop & !pop_ok.
  - Both cleared only by rst; reset value 0.
  - Under FORMAL, the environment assumption that legal traffic never sets them is also emitted.
- Undefined: the ports do not exist; illegal requests are still silently dropped.

Decomposition:
Package fifo_pkg holds:
- function cnt_width(depth) returning $clog2(depth+1)
- function ptr_width(depth) returning $clog2(depth), minimum 1
- a typedef for the error-flag pair, used when FIFO_ERR_FLAGS_EN is defined

Sub-module fifo_ptr (parameter DEPTH):
- Wrapping pointer register with enable; async active-low reset to 0.
- Instantiated once for wr_ptr and once for rd_ptr.
- Entry storage and count logic stay in fifo_thresh.

Test Plan:
1. DEPTH=5, WIDTH=8: push 0x11..0x15 on consecutive cycles → full=1, count=5; push 0x99 → dropped, count=5; pop ×5 → data_out sequence 0x11..0x15, empty=1.
2. DEPTH=5: fill, then push+pop together for 7 cycles with 0xA0..0xA6 → count stays 5; final drain returns the last five written words in order; pointers wrap through 4→0 twice.
3. Empty FIFO, push 0x3C + pop in the same cycle → count=1, data_out=0x3C next cycle; with FIFO_ERR_FLAGS_EN, underflow=1 and remains 1.
4. DEPTH=8, af_thresh=6, ae_thresh=2: push 7 words → almost_empty falls when count goes 2→3; almost_full rises at count=6; set af_thresh=8 → almost_full drops the same cycle.
5. After pushing 4 words, assert rst=0 asynchronously mid-cycle → count=0, empty=1, data_out=0 before the next clk edge; after release, push 0x55 → data_out=0x55.
6. DEPTH=2 corner: alternate push/pop for 10 cycles → count toggles 0/1, never full; data order preserved.
